// File: rtl/addr_gen_bwd_aifo_pkg.sv
// Shared LSTM buffer layout constants and the backward address generator state type.
// The forward writer uses the same constants, so both generators agree on t*NUM_CELL + c.
package addr_gen_bwd_aifo_pkg;

  localparam int LSTM_NUM_CELL   = 8;
  localparam int LSTM_TIMESTEP   = 7;
  localparam int LSTM_ADDR_WIDTH = 12;
  localparam int ACT_BUF_BASE    = 0;
  localparam int BWD_HOLD        = 8;
  localparam int BWD_DELAY       = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bwd_state_e;

  // Counter width for a range of values 0..range-1; a single-value range still needs one bit.
  function automatic int cnt_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/addr_gen_bwd_aifo_if.sv
// Control/read-port bundle between the BPTT controller, the generator and the activation RAM.
interface addr_gen_bwd_aifo_if
  import addr_gen_bwd_aifo_pkg::*;
#(
  parameter int ADDR_WIDTH = LSTM_ADDR_WIDTH
);
  logic                  start;
  logic                  en;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic                  o_valid;
  logic                  o_first;
  logic                  o_step_last;
  logic                  o_busy;
  logic                  o_done;

  modport master (
    output start, en,
    input  o_addr, o_valid, o_first, o_step_last, o_busy, o_done
  );

  modport slave (
    input  start, en,
    output o_addr, o_valid, o_first, o_step_last, o_busy, o_done
  );
endinterface

// File: rtl/addr_gen_bwd_aifo_period_cnt.sv
// HOLD+DELAY period counter: valid window, load strobe and end-of-period tick.
module bwd_period_cnt
  import addr_gen_bwd_aifo_pkg::*;
#(
  parameter int HOLD  = BWD_HOLD,
  parameter int DELAY = BWD_DELAY
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic adv_i,
  output logic valid_o,
  output logic first_o,
  output logic period_end_o
);
  localparam int PERIOD = HOLD + DELAY;
  localparam int CW     = cnt_width(PERIOD);
  localparam logic [CW-1:0] LAST   = CW'(PERIOD - 1);
  localparam logic [CW:0]   HOLD_W = (CW + 1)'(HOLD);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!active_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Extra bit keeps HOLD == 2**CW representable in the compare.
  assign valid_o      = active_i && ({1'b0, cnt_q} < HOLD_W);
  assign first_o      = active_i && (cnt_q == '0);
  assign period_end_o = active_i && (cnt_q == LAST);

endmodule

// File: rtl/addr_gen_bwd_aifo.sv
// Timestep-reversed read address generator for the a/i/f/o activation buffer during BPTT.
module addr_gen_bwd_aifo
  import addr_gen_bwd_aifo_pkg::*;
#(
  parameter int ADDR_WIDTH = LSTM_ADDR_WIDTH,
  parameter int NUM_CELL   = LSTM_NUM_CELL,
  parameter int TIMESTEP   = LSTM_TIMESTEP,
  parameter int HOLD       = BWD_HOLD,
  parameter int DELAY      = BWD_DELAY,
  parameter int BASE_ADDR  = ACT_BUF_BASE
) (
  input  logic                 clk,
  input  logic                 rst,
  addr_gen_bwd_aifo_if.slave   bus
);
  localparam int CELL_W = cnt_width(NUM_CELL);
  localparam int STEP_W = cnt_width(TIMESTEP);
  localparam logic [CELL_W-1:0]     CELL_LAST  = CELL_W'(NUM_CELL - 1);
  localparam logic [STEP_W-1:0]     STEP_LAST  = STEP_W'(TIMESTEP - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_BASE  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_START = ADDR_WIDTH'(BASE_ADDR + (TIMESTEP - 1) * NUM_CELL);
  localparam logic [ADDR_WIDTH-1:0] ADDR_BACK  = ADDR_WIDTH'(2 * NUM_CELL - 1);

  if ((longint'(BASE_ADDR) + longint'(NUM_CELL) * longint'(TIMESTEP) - 1) >= (longint'(1) << ADDR_WIDTH))
  begin : g_addr_overflow
    $error("addr_gen_bwd_aifo: ADDR_WIDTH too small for BASE_ADDR + NUM_CELL*TIMESTEP - 1");
  end

  bwd_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CELL_W-1:0]       cell_q, cell_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic                    run;
  logic                    period_end;

  assign run = (state_q == ST_RUN);

  bwd_period_cnt #(
    .HOLD  (HOLD),
    .DELAY (DELAY)
  ) u_period (
    .clk          (clk),
    .rst          (rst),
    .active_i     (run),
    .adv_i        (bus.en),
    .valid_o      (bus.o_valid),
    .first_o      (bus.o_first),
    .period_end_o (period_end)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cell_d  = cell_q;
    step_d  = step_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && bus.en) begin
          state_d = ST_RUN;
          addr_d  = ADDR_START;
          cell_d  = '0;
          step_d  = STEP_LAST;
        end
      end
      ST_RUN: begin
        if (bus.en && period_end) begin
          if (cell_q != CELL_LAST) begin
            cell_d = cell_q + CELL_W'(1);
            addr_d = addr_q + ADDR_WIDTH'(1);
          end else if (step_q != '0) begin
            // Last cell of step t back to cell 0 of step t-1.
            cell_d = '0;
            step_d = step_q - STEP_W'(1);
            addr_d = addr_q - ADDR_BACK;
          end else begin
            state_d = ST_DONE;
            addr_d  = ADDR_BASE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cell_q  <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cell_q  <= cell_d;
      step_q  <= step_d;
    end
  end

  assign bus.o_addr      = addr_q;
  assign bus.o_busy      = run;
  assign bus.o_done      = (state_q == ST_DONE);
  assign bus.o_step_last = run && (cell_q == CELL_LAST);

endmodule

// File: tb/tb_addr_gen_bwd_aifo.sv
// Bench for addr_gen_bwd_aifo: default-parameter DUT against an arithmetic sweep model,
// plus a directed check of a one-address boundary configuration.
module tb_addr_gen_bwd_aifo;

  localparam int NC     = 8;
  localparam int TS     = 7;
  localparam int HOLD   = 8;
  localparam int DELAY  = 2;
  localparam int P      = HOLD + DELAY;
  localparam int TOTAL  = NC * TS * P;
  localparam int BASE   = 0;
  localparam int BUDGET = 3000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // Model: mode 0 idle, 1 run, 2 done; n = en-high RUN cycles since accept.
  int m_mode = 0;
  int m_n    = 0;
  int m_idle_addr = 0;

  always #5 clk = ~clk;

  addr_gen_bwd_aifo_if #(.ADDR_WIDTH(12)) bus ();
  addr_gen_bwd_aifo_if #(.ADDR_WIDTH(12)) bb ();

  addr_gen_bwd_aifo #(
    .ADDR_WIDTH(12), .NUM_CELL(NC), .TIMESTEP(TS),
    .HOLD(HOLD), .DELAY(DELAY), .BASE_ADDR(BASE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  addr_gen_bwd_aifo #(
    .ADDR_WIDTH(12), .NUM_CELL(1), .TIMESTEP(1),
    .HOLD(1), .DELAY(0), .BASE_ADDR(100)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(input int k);
    int t, c;
    t = TS - 1 - k / NC;
    c = k % NC;
    return BASE + t * NC + c;
  endfunction

  task automatic step();
    int k, ph;
    @(posedge clk);
    if (!rst) begin
      m_mode = 0; m_n = 0; m_idle_addr = 0;
    end else begin
      case (m_mode)
        0: if (bus.start && bus.en) begin m_mode = 1; m_n = 0; end
        1: if (bus.en) begin
             m_n++;
             if (m_n == TOTAL) m_mode = 2;
           end
        default: begin m_mode = 0; m_idle_addr = BASE; end
      endcase
    end
    #1;
    if (m_mode == 1) begin
      k  = m_n / P;
      ph = m_n % P;
      chk("addr",      bus.o_addr,      exp_addr(k));
      chk("valid",     bus.o_valid,     (ph < HOLD) ? 1 : 0);
      chk("first",     bus.o_first,     (ph == 0) ? 1 : 0);
      chk("step_last", bus.o_step_last, (k % NC == NC - 1) ? 1 : 0);
      chk("busy",      bus.o_busy,      1);
      chk("done",      bus.o_done,      0);
    end else begin
      chk("addr",      bus.o_addr,      (m_mode == 2) ? BASE : m_idle_addr);
      chk("valid",     bus.o_valid,     0);
      chk("first",     bus.o_first,     0);
      chk("step_last", bus.o_step_last, 0);
      chk("busy",      bus.o_busy,      0);
      chk("done",      bus.o_done,      (m_mode == 2) ? 1 : 0);
    end
  endtask

  // en_mode: 0 always high, 1 alternating starting low, 2 random.
  task automatic sweep(input int en_mode, input bit poke_start, input int exp_lat, input string tag);
    int  cyc     = 0;
    int  done_at = -1;
    bit  seen    = 1'b0;
    bus.start = 1'b1;
    bus.en    = 1'b1;
    step();
    bus.start = 1'b0;
    while (!(seen && m_mode == 0) && cyc < BUDGET) begin
      case (en_mode)
        0:       bus.en = 1'b1;
        1:       bus.en = (cyc % 2 == 1);
        default: bus.en = ($urandom_range(0, 3) != 0);
      endcase
      bus.start = poke_start && ((m_mode == 2) || ($urandom_range(0, 7) == 0));
      step();
      cyc++;
      if (bus.o_done === 1'b1 && done_at < 0) done_at = cyc;
      if (m_mode == 2) seen = 1'b1;
    end
    bus.start = 1'b0;
    chk({tag, "_finished"}, (cyc < BUDGET) ? 1 : 0, 1);
    if (exp_lat > 0) chk({tag, "_done_latency"}, done_at, exp_lat);
  endtask

  initial begin
    int cyc;
    bus.start = 1'b0;
    bus.en    = 1'b0;
    bb.start  = 1'b0;
    bb.en     = 1'b1;
    rst       = 1'b0;
    step();
    step();
    chk("rst_b_busy", bb.o_busy, 0);
    chk("rst_b_addr", bb.o_addr, 0);
    rst = 1'b1;

    // One-address configuration: single valid cycle, then done.
    bb.start = 1'b1;
    step();
    bb.start = 1'b0;
    chk("b_addr",      bb.o_addr,      100);
    chk("b_valid",     bb.o_valid,     1);
    chk("b_first",     bb.o_first,     1);
    chk("b_step_last", bb.o_step_last, 1);
    chk("b_busy",      bb.o_busy,      1);
    chk("b_done0",     bb.o_done,      0);
    step();
    chk("b_done1",     bb.o_done,      1);
    chk("b_busy_done", bb.o_busy,      0);
    chk("b_valid_done", bb.o_valid,    0);
    chk("b_addr_done", bb.o_addr,      100);
    step();
    chk("b_done_pulse", bb.o_done,     0);

    // start with en low in IDLE must be ignored
    bus.start = 1'b1;
    bus.en    = 1'b0;
    step();
    bus.start = 1'b0;
    chk("start_en0_busy", bus.o_busy, 0);

    sweep(0, 1'b0, TOTAL,     "sweep_en1");
    sweep(1, 1'b0, 2 * TOTAL, "sweep_entog");
    sweep(2, 1'b1, -1,        "sweep_rand");

    // Mid-sweep reset at address 43, hold phase 5.
    bus.start = 1'b1;
    bus.en    = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 0;
    while (!(m_mode == 1 && m_n == P * (NC + 3) + 5) && cyc < BUDGET) begin
      step();
      cyc++;
    end
    chk("mid_reached", (cyc < BUDGET) ? 1 : 0, 1);
    chk("mid_addr",    bus.o_addr, 43);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_rst_addr", bus.o_addr, 0);
    chk("mid_rst_busy", bus.o_busy, 0);

    sweep(0, 1'b1, TOTAL, "sweep_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/addr_gen_bwd_aifo.md
Name: addr_gen_bwd_aifo

Overview:
Read address generator for the stored activation results (a, i, f, o gate buffer) during backward propagation through time. The forward pass writes this buffer at address t*NUM_CELL + c. This block reads it back timestep-reversed: t = TIMESTEP-1 down to 0, and c = 0 to NUM_CELL-1 within each step. Each address is held for one backward compute period. It sits between the BPTT controller (start/en) and the activation RAM read port.

Parameters:
ADDR_WIDTH, 12, width of o_addr; must hold BASE_ADDR + NUM_CELL*TIMESTEP - 1
NUM_CELL, 8, cells per timestep
TIMESTEP, 7, number of timesteps stored
HOLD, 8, cycles o_addr is valid per address (recurrent dot-product length)
DELAY, 2, pipeline gap cycles after HOLD before the next address
BASE_ADDR, 0, base of the activation buffer

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-low reset (rst==0 at posedge resets)
start  in  1  one-cycle request to begin a backward sweep; honoured only in IDLE
en  in  1  advance enable; en==0 freezes all state and outputs
o_addr  out  ADDR_WIDTH  activation RAM read address
o_valid  out  1  o_addr is inside its HOLD window
o_first  out  1  first cycle of an address period (load strobe)
o_step_last  out  1  current address is the last cell of its timestep
o_busy  out  1  sweep in progress (state RUN)
o_done  out  1  one-cycle pulse when the sweep completes

Behaviour:
- All outputs are registered or decoded from registered state only (Moore); no comb path from start/en to outputs.
- Reset (rst==0): state=IDLE; o_addr=0; cell_cnt=0; step_cnt=0; hold_cnt=0; o_valid=o_first=o_step_last=o_busy=o_done=0. Reset applies at any time, including mid-sweep, and wins over start/en.
- States are IDLE, RUN and DONE.
- IDLE: if start==1 && en==1, go to RUN next cycle with:
  - o_addr = BASE_ADDR + (TIMESTEP-1)*NUM_CELL
  - step_cnt = TIMESTEP-1, cell_cnt = 0, hold_cnt = 0.
  - start with en==0 is ignored.
- RUN, en==1 (hold_cnt runs 0..HOLD+DELAY-1):
  - If hold_cnt < HOLD+DELAY-1: hold_cnt+1.
  - Else hold_cnt=0 and one of:
    - cell_cnt < NUM_CELL-1: cell_cnt+1, o_addr+1.
    - cell_cnt == NUM_CELL-1 && step_cnt > 0: cell_cnt=0, step_cnt-1, o_addr = o_addr - (2*NUM_CELL-1).
    - cell_cnt == NUM_CELL-1 && step_cnt == 0: go to DONE.
- RUN, en==0: all counters, o_addr and state hold.
- Decoded outputs:
  - o_valid = RUN && hold_cnt < HOLD.
  - o_first = RUN && hold_cnt == 0.
  - o_step_last = RUN && cell_cnt == NUM_CELL-1.
  - o_busy = RUN.
- DONE: o_done=1 for exactly one cycle; o_addr holds BASE_ADDR; next cycle go to IDLE (not gated by en). start is ignored in RUN and DONE.
- Latency and totals:
  - Start accepted at edge k → first valid address visible after edge k.
  - Sweep length is TIMESTEP*NUM_CELL*(HOLD+DELAY) en-high cycles; default 560.
  - o_done rises after the 560th en-high RUN cycle.
- Arithmetic: counters are sized by $clog2 of their range. Address subtraction never underflows, because the lowest address reached is BASE_ADDR. Exceeding ADDR_WIDTH is a parameterisation error; flag it with an elaboration-time check.

Decomposition:
- Shared LSTM package: NUM_CELL, TIMESTEP, ADDR_WIDTH, and the activation buffer base constants. The same constants serve the forward writer, so both address generators use an identical layout.
- State encoding is a localparam in this module.
- One natural sub-module: bwd_period_cnt, the HOLD+DELAY period counter. It outputs o_valid/o_first and a period_end tick, and can be reused by the backward weight address generators.

Test Plan:
- Reset then single sweep, en=1 always, defaults → o_addr sequence 48..55, 40..47, ..., 0..7. Each address held 10 cycles; o_valid high for the first 8 of each 10; o_done a single pulse 560 cycles after start accept; then o_busy=0.
- en toggled 1010... during RUN → o_addr/o_valid frozen on en=0 cycles; sequence identical to the previous test; o_done after 1120 cycles.
- start pulsed during RUN and during the DONE cycle → ignored; no restart. A start in the cycle after DONE (IDLE) begins a new sweep at o_addr=48.
- rst=0 asserted mid-sweep (o_addr=43, hold_cnt=5) → next cycle all outputs 0, state IDLE; a subsequent start restarts from 48.
- Boundary params NUM_CELL=1, TIMESTEP=1, HOLD=1, DELAY=0, BASE_ADDR=100 → o_addr=100 valid one cycle with o_first=o_step_last=1, then o_done pulse.
- o_step_last check, defaults → high only while o_addr ∈ {55,47,39,31,23,15,7}.
